// File: rtl/i2c_master.sv
// Byte-oriented I2C master for single-byte register writes and reads.
// Write: S, {chip,0}, register address bytes (MSB first), data, P.
// Read:  S, {chip,0}, register address bytes, Sr, {chip,1}, one byte, master NACK, P.
// SDA/SCL are open drain: the *_out pins are tied low and the *_oeb pins
// select between release (1) and drive-low (0). The slave may stretch SCL.
//
// Handshake: start is a one-cycle request that is accepted only in a cycle
// where busy=0, and rw/chip_addr/reg_addr/datai are captured in that same
// cycle. busy rises the cycle after acceptance and falls in the cycle done
// pulses. datao is valid while done=1 with nack=0, and it holds its value
// until the next read completes. A new start in the done cycle is accepted.
module i2c_master #(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int CLK_DIV        = 30
) (
  input  logic                        ifclk,
  input  logic                        resetb,
  input  logic                        start,
  input  logic                        rw,
  input  logic [6:0]                  chip_addr,
  input  logic [8*NUM_ADDR_BYTES-1:0] reg_addr,
  input  logic [7:0]                  datai,
  output logic [7:0]                  datao,
  output logic                        busy,
  output logic                        done,
  output logic                        nack,
  input  logic                        sda_in,
  input  logic                        scl_in,
  output logic                        sda_out,
  output logic                        sda_oeb,
  output logic                        scl_out,
  output logic                        scl_oeb,
  output logic [2:0]                  dbg_state
);

  localparam int AW    = 8 * NUM_ADDR_BYTES;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       ADDR_LAST = 3'(NUM_ADDR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_TX     = 3'd2,
    S_TACK   = 3'd3,
    S_RSTART = 3'd4,
    S_RX     = 3'd5,
    S_MNACK  = 3'd6,
    S_STOP   = 3'd7
  } state_t;

  state_t             state, state_n;
  logic [1:0]         phase, phase_n;
  logic [DIV_W-1:0]   div_cnt;
  logic               sda_s1, sda_sync, scl_s1, scl_sync;
  logic               sda_rel, scl_rel;
  logic               advance, start_acc;
  logic [7:0]         tx_sr, rx_sr, data_q;
  logic [6:0]         chip_q;
  logic [AW-1:0]      addr_sr;
  logic [2:0]         bit_cnt, byte_idx;
  logic               rw_q, ack_q;

  assign sda_out   = 1'b0;
  assign scl_out   = 1'b0;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign start_acc = (state == S_IDLE) && start;
  // A phase ends on the divider tick, but a phase that releases SCL waits
  // until the bus actually shows SCL high (clock stretching).
  assign advance   = (state != S_IDLE) && (div_cnt == DIV_LAST) && (!scl_rel || scl_sync);

  // Two-flop synchronizers on the pad inputs; idle bus reads as high.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      sda_s1   <= 1'b1;
      sda_sync <= 1'b1;
      scl_s1   <= 1'b1;
      scl_sync <= 1'b1;
    end else begin
      sda_s1   <= sda_in;
      sda_sync <= sda_s1;
      scl_s1   <= scl_in;
      scl_sync <= scl_s1;
    end
  end

  // State and quarter-phase registers.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state <= S_IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // Next-state logic: transitions happen at the end of the q3 phase of a bit.
  always_comb begin
    state_n = state;
    phase_n = phase;
    if (start_acc) begin
      state_n = S_START;
      phase_n = 2'd0;
    end else if (advance) begin
      phase_n = phase + 2'd1;
      if (phase == 2'd3) begin
        case (state)
          S_START:  state_n = S_TX;
          S_TX:     if (bit_cnt == 3'd7) state_n = S_TACK;
          S_TACK: begin
            if (ack_q)                              state_n = S_STOP;
            else if (byte_idx == ADDR_LAST + 3'd1)  state_n = rw_q ? S_RX : S_STOP;
            else if (byte_idx == ADDR_LAST && rw_q) state_n = S_RSTART;
            else                                    state_n = S_TX;
          end
          S_RSTART: state_n = S_TX;
          S_RX:     if (bit_cnt == 3'd7) state_n = S_MNACK;
          S_MNACK:  state_n = S_STOP;
          S_STOP:   state_n = S_IDLE;
          default:  state_n = S_IDLE;
        endcase
      end
    end
  end

  // Line levels wanted for the current state and phase (1 = release).
  always_comb begin
    sda_rel = 1'b1;
    scl_rel = 1'b1;
    case (state)
      S_START: begin
        sda_rel = (phase == 2'd0);
        scl_rel = (phase != 2'd3);
      end
      S_TX: begin
        sda_rel = tx_sr[7];
        scl_rel = (phase == 2'd1) || (phase == 2'd2);
      end
      S_TACK, S_RX, S_MNACK: begin
        scl_rel = (phase == 2'd1) || (phase == 2'd2);
      end
      S_RSTART: begin
        sda_rel = (phase <= 2'd1);
        scl_rel = (phase == 2'd1) || (phase == 2'd2);
      end
      S_STOP: begin
        sda_rel = (phase == 2'd3);
        scl_rel = (phase != 2'd0);
      end
      default: begin
        sda_rel = 1'b1;
        scl_rel = 1'b1;
      end
    endcase
  end

  // Registered pad enables so the pads never see decode glitches.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      sda_oeb <= 1'b1;
      scl_oeb <= 1'b1;
    end else begin
      sda_oeb <= sda_rel;
      scl_oeb <= scl_rel;
    end
  end

  // Datapath: request capture, phase divider, byte sequencing and read capture.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      div_cnt  <= '0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      data_q   <= 8'd0;
      chip_q   <= 7'd0;
      addr_sr  <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      datao    <= 8'd0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_acc) begin
        rw_q     <= rw;
        chip_q   <= chip_addr;
        data_q   <= datai;
        addr_sr  <= reg_addr;
        tx_sr    <= {chip_addr, 1'b0};
        bit_cnt  <= 3'd0;
        byte_idx <= 3'd0;
        ack_q    <= 1'b0;
        nack     <= 1'b0;
      end
      if (state == S_IDLE || advance)
        div_cnt <= '0;
      else if (div_cnt != DIV_LAST)
        div_cnt <= div_cnt + 1'b1;
      if (advance && phase == 2'd2) begin
        if (state == S_TACK) ack_q <= sda_sync;
        if (state == S_RX)   rx_sr <= {rx_sr[6:0], sda_sync};
      end
      if (advance && phase == 2'd3) begin
        case (state)
          S_TX: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sr   <= {tx_sr[6:0], 1'b0};
            end
          end
          S_TACK: begin
            if (ack_q) begin
              nack <= 1'b1;
            end else if (byte_idx < ADDR_LAST) begin
              tx_sr    <= addr_sr[AW-1 -: 8];
              addr_sr  <= addr_sr << 8;
              byte_idx <= byte_idx + 3'd1;
            end else if (byte_idx == ADDR_LAST) begin
              tx_sr    <= rw_q ? {chip_q, 1'b1} : data_q;
              byte_idx <= byte_idx + 3'd1;
            end
          end
          S_RX: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              datao   <= rx_sr;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_STOP:  done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus with a behavioural register slave at
// address 104, directed write/read/no-ack/stretch/reset scenarios.
module tb_i2c_master;

  localparam int NAB     = 2;
  localparam int DIV     = 10;
  localparam logic [6:0] SLV_ADDR = 7'd104;

  logic            ifclk;
  logic            resetb;
  logic            start;
  logic            rw;
  logic [6:0]      chip_addr;
  logic [8*NAB-1:0] reg_addr;
  logic [7:0]      datai;
  logic [7:0]      datao;
  logic            busy, done, nack;
  logic            sda_out, sda_oeb, scl_out, scl_oeb;
  logic [2:0]      dbg_state;
  logic            bus_sda, bus_scl;
  logic            s_sda_rel = 1'b1;
  logic            s_scl_rel = 1'b1;

  assign bus_sda = sda_oeb & s_sda_rel;
  assign bus_scl = scl_oeb & s_scl_rel;

  i2c_master #(.NUM_ADDR_BYTES(NAB), .CLK_DIV(DIV)) dut (
    .ifclk     (ifclk),
    .resetb    (resetb),
    .start     (start),
    .rw        (rw),
    .chip_addr (chip_addr),
    .reg_addr  (reg_addr),
    .datai     (datai),
    .datao     (datao),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .sda_in    (bus_sda),
    .scl_in    (bus_scl),
    .sda_out   (sda_out),
    .sda_oeb   (sda_oeb),
    .scl_out   (scl_out),
    .scl_oeb   (scl_oeb),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    ifclk = 1'b0;
    forever #5 ifclk = ~ifclk;
  end

  // Scoreboard state
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] bus_q[$];
  int         n_start = 0;
  int         n_stop = 0;
  logic       mack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < bus_q.size()) check($sformatf("%s_byte%0d", tag, i), bus_q[i], exp_q[i]);
    end
  endtask

  task automatic clear_bus();
    bus_q.delete();
    exp_q.delete();
    n_start = 0;
    n_stop  = 0;
  endtask

  // Slave model, sampled on the falling system clock away from DUT updates.
  logic [7:0] rd_byte = 8'h00;
  logic       str_en = 1'b0;
  int         str_cnt = 0;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         sl_phase = 0;
  int         sl_bit = 0;
  logic [7:0] sl_sr = 8'h00;
  logic [7:0] sl_tx = 8'h00;
  logic       sl_first = 1'b0, sl_match = 1'b0, sl_read = 1'b0;

  always @(negedge ifclk) begin
    if (str_cnt > 0) begin
      str_cnt--;
      if (str_cnt == 0) s_scl_rel = 1'b1;
    end
    if (p_scl && bus_scl && p_sda && !bus_sda) begin
      n_start++;
      sl_phase = 1; sl_bit = 0; sl_first = 1'b1; s_sda_rel = 1'b1;
    end else if (p_scl && bus_scl && !p_sda && bus_sda) begin
      n_stop++;
      sl_phase = 0; s_sda_rel = 1'b1;
    end else if (!p_scl && bus_scl) begin
      if (sl_phase == 1) begin
        sl_sr = {sl_sr[6:0], bus_sda};
        sl_bit++;
      end else if (sl_phase == 4) begin
        mack = bus_sda;
      end
    end else if (p_scl && !bus_scl) begin
      case (sl_phase)
        1: begin
          if (sl_bit == 8) begin
            bus_q.push_back(sl_sr);
            if (sl_first) begin
              sl_match = (sl_sr[7:1] == SLV_ADDR);
              sl_read  = sl_sr[0];
              sl_first = 1'b0;
            end
            if (sl_match) s_sda_rel = 1'b0;
            sl_phase = 2;
          end else if (sl_bit == 3 && str_en && bus_q.size() == 1) begin
            s_scl_rel = 1'b0;
            str_cnt   = 500;
            str_en    = 1'b0;
          end
        end
        2: begin
          s_sda_rel = 1'b1;
          sl_bit = 0;
          if (!sl_match) sl_phase = 0;
          else if (sl_read) begin
            sl_phase = 3;
            sl_tx = rd_byte;
            s_sda_rel = sl_tx[7];
          end else sl_phase = 1;
        end
        3: begin
          sl_bit++;
          if (sl_bit == 8) begin
            s_sda_rel = 1'b1;
            sl_phase = 4;
          end else s_sda_rel = sl_tx[7 - sl_bit];
        end
        4: sl_phase = 0;
        default: ;
      endcase
    end
    p_scl = bus_scl;
    p_sda = bus_sda;
  end

  // Driver: issue one transaction and count cycles until done.
  task automatic run_txn(input logic t_rw, input logic [6:0] t_chip, input logic [15:0] t_reg,
                         input logic [7:0] t_data, input int glitch_at, output int cyc);
    rw = t_rw; chip_addr = t_chip; reg_addr = t_reg; datai = t_data;
    start = 1'b1;
    @(posedge ifclk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("nack_cleared_on_start", nack, 1'b0);
    cyc = 1;
    while (cyc < 20000) begin
      @(posedge ifclk); #1;
      if (cyc == glitch_at) begin
        start = 1'b1; rw = 1'b1; chip_addr = 7'h22;
      end else start = 1'b0;
      if (done) break;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 20000) check("done_timeout", 1'b0, 1'b1);
  endtask

  // Main sequence
  initial begin
    int cyc;
    resetb = 1'b0; start = 1'b0; rw = 1'b0; chip_addr = 7'd0; reg_addr = '0; datai = 8'd0;

    // 1. reset values and idle bus
    #23;
    check("rst_sda_oeb", sda_oeb, 1'b1);
    check("rst_scl_oeb", scl_oeb, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_datao", datao, 8'h00);
    check("rst_state", dbg_state, 3'd0);
    check("sda_out_low", sda_out, 1'b0);
    check("scl_out_low", scl_out, 1'b0);
    resetb = 1'b1;
    repeat (100) @(posedge ifclk);
    #1;
    check("idle_sda_oeb", sda_oeb, 1'b1);
    check("idle_scl_oeb", scl_oeb, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_no_start", n_start, 0);

    // 2. write chip 104 reg 0x0012 data 0xA5
    clear_bus();
    exp_q.push_back(8'hD0); exp_q.push_back(8'h00); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
    run_txn(1'b0, 7'd104, 16'h0012, 8'hA5, -1, cyc);
    check("wr_cycles", cyc, 1520);
    check("wr_nack", nack, 1'b0);
    check("wr_busy_at_done", busy, 1'b0);
    check("wr_starts", n_start, 1);
    check("wr_stops", n_stop, 1);
    check_bytes("wr");

    // 3. read chip 104 reg 0x0003, issued in the done cycle (back-to-back)
    clear_bus();
    rd_byte = 8'h5C;
    mack = 1'b0;
    exp_q.push_back(8'hD0); exp_q.push_back(8'h00); exp_q.push_back(8'h03); exp_q.push_back(8'hD1);
    run_txn(1'b1, 7'd104, 16'h0003, 8'h00, -1, cyc);
    check("rd_cycles", cyc, 1920);
    check("rd_datao", datao, 8'h5C);
    check("rd_nack", nack, 1'b0);
    check("rd_master_nack", mack, 1'b1);
    check("rd_starts_incl_sr", n_start, 2);
    check("rd_stops", n_stop, 1);
    check_bytes("rd");

    // 4. absent slave 0x22: STOP after first byte, nack set
    repeat (20) @(posedge ifclk);
    #1;
    clear_bus();
    exp_q.push_back(8'h44);
    run_txn(1'b0, 7'h22, 16'h0001, 8'h11, -1, cyc);
    check("na_cycles", cyc, 440);
    check("na_nack", nack, 1'b1);
    check("na_datao_held", datao, 8'h5C);
    check("na_stops", n_stop, 1);
    check_bytes("na");
    @(posedge ifclk); #1;
    check("na_done_one_cycle", done, 1'b0);
    check("na_nack_held", nack, 1'b1);

    // 5. slave stretches bit 3 of byte 1 for 500 cycles; start while busy ignored
    repeat (20) @(posedge ifclk);
    #1;
    clear_bus();
    str_en = 1'b1;
    exp_q.push_back(8'hD0); exp_q.push_back(8'h00); exp_q.push_back(8'h34); exp_q.push_back(8'h3C);
    run_txn(1'b0, 7'd104, 16'h0034, 8'h3C, 700, cyc);
    check("st_cycles_in_range", (cyc >= 1990 && cyc <= 1998), 1'b1);
    check("st_nack", nack, 1'b0);
    repeat (60) @(posedge ifclk);
    #1;
    check("st_ignored_start_busy", busy, 1'b0);
    check("st_starts", n_start, 1);
    check_bytes("st");

    // 6. reset mid-byte releases both lines at once, then a clean write
    clear_bus();
    rw = 1'b0; chip_addr = 7'd104; reg_addr = 16'h5678; datai = 8'h9A;
    start = 1'b1;
    @(posedge ifclk); #1;
    start = 1'b0;
    repeat (285) begin
      @(posedge ifclk); #1;
    end
    check("mid_sda_oeb_low", sda_oeb, 1'b0);
    check("mid_scl_oeb_low", scl_oeb, 1'b0);
    #2 resetb = 1'b0;
    #1;
    check("async_sda_oeb", sda_oeb, 1'b1);
    check("async_scl_oeb", scl_oeb, 1'b1);
    check("async_busy", busy, 1'b0);
    check("async_state", dbg_state, 3'd0);
    repeat (5) @(posedge ifclk);
    #1 resetb = 1'b1;
    repeat (20) @(posedge ifclk);
    #1;
    check("post_rst_stops", n_stop, 0);
    clear_bus();
    exp_q.push_back(8'hD0); exp_q.push_back(8'h56); exp_q.push_back(8'h78); exp_q.push_back(8'h9A);
    run_txn(1'b0, 7'd104, 16'h5678, 8'h9A, -1, cyc);
    check("rw_cycles", cyc, 1520);
    check("rw_nack", nack, 1'b0);
    check_bytes("rw");

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
